// File: rtl/march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : march_bist_ctrl
// Brief    : Parametrised single-port SRAM March C- / March A BIST engine
//            with on-chip compare. Optional capture: BIST_DIAG_EN.
// Revision : 1.0
// ============================================================================
module march_bist_ctrl #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 8,
  parameter int READ_LAT     = 4,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic              alg_sel,
  input  logic [DATA_W-1:0] dat_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] dat_out,
  output logic              w_en_out,
  output logic              busy,
  output logic              rst_done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  // NEXT is folded into the op-ending cycle so ops stay back-to-back.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OP_W   = 3'd1,
    OP_R   = 3'd2,
    R_WAIT = 3'd3,
    R_CMP  = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_max  = '1;
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [3:0]        c_wait_last = 4'(READ_LAT - 1);

  state_t            r_state, state_n;
  logic              r_alg, alg_n;
  logic [2:0]        r_elem, elem_n;
  logic [1:0]        r_op, op_n;
  logic [ADDR_W-1:0] r_addr, addr_n;
  logic [3:0]        r_cnt, cnt_n;
  logic              r_fail, fail_n;

  logic              w_start, w_mismatch, w_adv, w_finish;
  logic              w_last_op, w_last_addr, w_last_elem, w_down, w_busy;
  logic [1:0]        w_op, w_nxt_op;
  logic [DATA_W-1:0] w_exp;

  // Op table entry: {is_write, data value}.
  function automatic logic [1:0] f_op(input logic alg, input logic [2:0] elem,
                                      input logic [1:0] op);
    case ({alg, elem, op})
      6'b0_000_00: f_op = 2'b10;
      6'b0_001_00: f_op = 2'b00;
      6'b0_001_01: f_op = 2'b11;
      6'b0_010_00: f_op = 2'b01;
      6'b0_010_01: f_op = 2'b10;
      6'b0_011_00: f_op = 2'b00;
      6'b0_011_01: f_op = 2'b11;
      6'b0_100_00: f_op = 2'b01;
      6'b0_100_01: f_op = 2'b10;
      6'b0_101_00: f_op = 2'b00;
      6'b1_000_00: f_op = 2'b10;
      6'b1_001_00: f_op = 2'b00;
      6'b1_001_01: f_op = 2'b11;
      6'b1_001_10: f_op = 2'b10;
      6'b1_001_11: f_op = 2'b11;
      6'b1_010_00: f_op = 2'b01;
      6'b1_010_01: f_op = 2'b10;
      6'b1_010_10: f_op = 2'b11;
      6'b1_011_00: f_op = 2'b01;
      6'b1_011_01: f_op = 2'b10;
      6'b1_011_10: f_op = 2'b11;
      6'b1_011_11: f_op = 2'b10;
      6'b1_100_00: f_op = 2'b00;
      6'b1_100_01: f_op = 2'b11;
      6'b1_100_10: f_op = 2'b10;
      default:     f_op = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] f_last_op(input logic alg, input logic [2:0] elem);
    case ({alg, elem})
      4'b0_001, 4'b0_010, 4'b0_011, 4'b0_100: f_last_op = 2'd1;
      4'b1_001, 4'b1_011:                     f_last_op = 2'd3;
      4'b1_010, 4'b1_100:                     f_last_op = 2'd2;
      default:                                f_last_op = 2'd0;
    endcase
  endfunction

  // Both algorithms count down only in elements 3 and 4.
  function automatic logic f_down(input logic [2:0] elem);
    f_down = (elem == 3'd3) || (elem == 3'd4);
  endfunction

  assign w_op        = f_op(r_alg, r_elem, r_op);
  assign w_exp       = {DATA_W{w_op[0]}};
  assign w_busy      = (r_state != IDLE) && (r_state != DONE);
  assign w_start     = en_in && !w_busy;
  assign w_mismatch  = (r_state == R_CMP) && (dat_in != w_exp);
  assign w_down      = f_down(r_elem);
  assign w_last_op   = (r_op == f_last_op(r_alg, r_elem));
  assign w_last_addr = w_down ? (r_addr == '0) : (r_addr == c_addr_max);
  assign w_last_elem = (r_elem == (r_alg ? 3'd4 : 3'd5));

  always_comb begin
    state_n  = r_state;
    alg_n    = r_alg;
    elem_n   = r_elem;
    op_n     = r_op;
    addr_n   = r_addr;
    cnt_n    = r_cnt;
    fail_n   = r_fail;
    w_adv    = 1'b0;
    w_finish = 1'b0;
    w_nxt_op = 2'b00;
    case (r_state)
      IDLE, DONE: begin
        if (w_start) begin
          alg_n   = alg_sel;
          elem_n  = 3'd0;
          op_n    = 2'd0;
          addr_n  = '0;
          cnt_n   = 4'd0;
          fail_n  = 1'b0;
          state_n = OP_W;
        end
      end
      OP_W: w_adv = 1'b1;
      OP_R: begin
        if (READ_LAT == 1) begin
          state_n = R_CMP;
        end else begin
          state_n = R_WAIT;
          cnt_n   = 4'd1;
        end
      end
      R_WAIT: begin
        if (r_cnt == c_wait_last) state_n = R_CMP;
        else                      cnt_n   = r_cnt + 4'd1;
      end
      R_CMP: begin
        if (w_mismatch) fail_n = 1'b1;
        if (w_mismatch && STOP_ON_FAIL) w_finish = 1'b1;
        else                            w_adv    = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (w_adv) begin
      if (!w_last_op) begin
        op_n = r_op + 2'd1;
      end else begin
        op_n = 2'd0;
        if (!w_last_addr) begin
          addr_n = w_down ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
        end else if (!w_last_elem) begin
          elem_n = r_elem + 3'd1;
          addr_n = f_down(elem_n) ? c_addr_max : '0;
        end else begin
          w_finish = 1'b1;
        end
      end
      w_nxt_op = f_op(r_alg, elem_n, op_n);
      state_n  = w_nxt_op[1] ? OP_W : OP_R;
    end

    if (w_finish) begin
      state_n = DONE;
      elem_n  = 3'd0;
      op_n    = 2'd0;
      addr_n  = '0;
      cnt_n   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_alg   <= 1'b0;
      r_elem  <= 3'd0;
      r_op    <= 2'd0;
      r_addr  <= '0;
      r_cnt   <= 4'd0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= state_n;
      r_alg   <= alg_n;
      r_elem  <= elem_n;
      r_op    <= op_n;
      r_addr  <= addr_n;
      r_cnt   <= cnt_n;
      r_fail  <= fail_n;
    end
  end

  assign addr_out = r_addr;
  assign dat_out  = w_busy ? w_exp : '0;
  assign w_en_out = (r_state == OP_W);
  assign busy     = w_busy;
  assign rst_done = (r_state == DONE);
  assign pass     = (r_state == DONE) && !r_fail;
  assign fail     = r_fail;

`ifdef BIST_DIAG_EN
  logic [ADDR_W-1:0] r_fail_addr;
  logic [2:0]        r_fail_elem;
  logic [DATA_W-1:0] r_fail_data;

  // Only the first mismatch of a run is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_data <= '0;
    end else if (w_start) begin
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_data <= '0;
    end else if (w_mismatch && !r_fail) begin
      r_fail_addr <= r_addr;
      r_fail_elem <= r_elem;
      r_fail_data <= dat_in;
    end
  end

  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign fail_data = r_fail_data;
`else
  assign fail_addr = '0;
  assign fail_elem = 3'd0;
  assign fail_data = '0;
`endif

endmodule
`default_nettype wire

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- Parametrised SRAM memory-BIST controller; next generation of the fixed 4-bit/256-word March A engine.
- Generalised in data width, address depth and read latency.
- Runtime-selectable algorithm: March C- or March A.
- Adds on-chip compare, a sticky fail flag and a pass/done status; sits between the SoC test controller and one single-port SRAM.

Parameters:
- DATA_W, 4: SRAM word width.
- ADDR_W, 8: address width; N = 2^ADDR_W words tested.
- READ_LAT, 4: cycles from address drive to dat_in valid; legal range 1..15.
- STOP_ON_FAIL, 0: 1 = abort the run on the first mismatch.

Ports:
- clk, in, 1: single clock, all logic on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en_in, in, 1: start pulse; sampled only in IDLE or DONE.
- alg_sel, in, 1: 0 = March C-, 1 = March A; latched when en_in is accepted.
- dat_in, in, DATA_W: SRAM read data.
- addr_out, out, ADDR_W: SRAM address.
- dat_out, out, DATA_W: SRAM write data.
- w_en_out, out, 1: SRAM write enable; 0 = read.
- busy, out, 1: run in progress.
- rst_done, out, 1: run finished; held until the next accepted en_in.
- pass, out, 1: valid while rst_done = 1; 1 = no mismatch.
- fail, out, 1: sticky mismatch flag; live during the run.
- fail_addr, out, ADDR_W: diagnostic, see Optional Feature.
- fail_elem, out, 3: diagnostic, see Optional Feature.
- fail_data, out, DATA_W: diagnostic, see Optional Feature.

Behaviour:
- Reset values: addr_out = 0, dat_out = 0, w_en_out = 0, busy = 0, rst_done = 0, pass = 0, fail = 0, all diagnostic outputs = 0. FSM enters IDLE.
- Algorithms. "0" means all-zeros and "1" means all-ones of DATA_W. ⇑ = addresses 0..N-1; ⇓ = addresses N-1..0; ⇕ is implemented as ⇑.
  - March C-: E0 ⇕(w0); E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇕(r0).
  - March A: E0 ⇕(w0); E1 ⇑(r0,w1,w0,w1); E2 ⇑(r1,w0,w1); E3 ⇓(r1,w0,w1,w0); E4 ⇓(r0,w1,w0).
  - Element/op sequences are held in an internal table indexed by {alg, elem, op}.
- FSM states: IDLE, OP_W, OP_R, R_WAIT, R_CMP, NEXT, DONE.
- Start: en_in = 1 at edge k in IDLE or DONE:
  - clears rst_done, pass and fail; latches alg_sel; sets busy;
  - the first op occupies the cycle between edge k and edge k+1.
- Write op: 1 cycle; addr_out and dat_out valid, w_en_out = 1.
- Read op: READ_LAT+1 cycles.
  - addr_out is held for the whole op with w_en_out = 0; dat_out holds the expected value.
  - dat_in is compared at the edge ending the last cycle of the op.
  - Mismatch (any bit) sets fail.
- Op sequencing:
  - Ops run back-to-back with no idle cycles between ops, addresses or elements.
  - Within an address, all ops of the element complete before the address steps.
- Down-count: terminates after address 0. No underflow wrap; addr_out never visits N-1 twice in one element.
- Run length, in op cycles:
  - March C-: 5N writes + 5N reads × (READ_LAT+1).
  - March A: 11N writes + 4N reads × (READ_LAT+1).
- End of run: after the last op, at the following edge:
  - busy = 0, rst_done = 1, pass = ~fail;
  - w_en_out = 0, addr_out = 0.
- STOP_ON_FAIL = 1: the edge that detects a mismatch goes straight to DONE with pass = 0.
- en_in while busy: ignored.
- alg_sel changes mid-run: ignored.
- Reset mid-run: immediate return to reset values. No partial status is retained.

Optional Feature:
- Macro BIST_DIAG_EN.
- When defined: on the first mismatch of a run, capture and hold until the next accepted en_in:
  - fail_addr = address;
  - fail_elem = element index;
  - fail_data = dat_in.
- Later mismatches do not overwrite the capture.
- When undefined: fail_addr, fail_elem and fail_data are tied to 0 and no capture registers exist. fail and pass behave identically in both builds.

Test Plan:
- Ideal memory model, ADDR_W = 2, DATA_W = 4, READ_LAT = 1, alg_sel = 0, en_in at edge k -> rst_done rises at edge k+60, pass = 1, fail = 0; bus trace matches the March C- sequence.
- Same configuration, alg_sel = 1 -> rst_done at edge k+76, pass = 1; element E3 addresses observed 3,2,1,0, each with ops r1,w0,w1,w0.
- Stuck-at-0 on bit 2 of address 1, alg_sel = 0 -> fail rises during E2; final pass = 0. With BIST_DIAG_EN: fail_addr = 1, fail_elem = 2, fail_data = 4'b1011.
- STOP_ON_FAIL = 1 with the same fault -> rst_done rises at the edge after the first mismatching compare; no further writes issued.
- READ_LAT = 4, ADDR_W = 8 -> every read holds addr_out for 5 cycles; dat_in sampled on the 5th edge; a full March C- run takes 7680 cycles.
- rst_n pulsed low mid-E1, en_in pulsed twice while busy -> all outputs return to 0 asynchronously; the extra en_in pulses have no effect; a fresh en_in restarts from E0, address 0.
